// File: rtl/aurora_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aurora_pkt_pkg
//  Purpose  : Shared constants, header field offsets and FSM encoding for the
//             Aurora packet encapsulator / decapsulator pair.
//  Revision : 1.0  initial release
// ============================================================================
package aurora_pkt_pkg;

    localparam int DATA_WIDTH             = 1024;
    localparam int RECOGNIZE_ROUTER_WIDTH = 2;
    localparam int NUMBER_PACKET          = 19;
    localparam int TTL_WIDTH              = 2;
    localparam int BEAT_CNT_WIDTH         = $clog2(NUMBER_PACKET);
    localparam int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + BEAT_CNT_WIDTH + TTL_WIDTH;
    localparam int AURORA_DATA_WIDTH      = 64;
    localparam int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH;
    localparam int LAST_BEAT_BITS         = 34;
    localparam int LAST_BEAT              = NUMBER_PACKET - 1;
    localparam int PAD_LSB                = HEADER_WIDTH + LAST_BEAT_BITS;

    localparam int ROUTER_ID_LSB          = 0;
    localparam int TAG_LSB                = 2;
    localparam int TTL_LSB                = 7;

    localparam logic [1:0] C_ST_IDLE      = 2'd0;
    localparam logic [1:0] C_ST_COLLECT   = 2'd1;
    localparam logic [1:0] C_ST_CHECK     = 2'd2;

    function automatic logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id(
        input logic [HEADER_WIDTH-1:0] hdr
    );
        return hdr[ROUTER_ID_LSB +: RECOGNIZE_ROUTER_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decap_packet.sv
`default_nettype none
// ============================================================================
//  Module   : decap_packet
//  Purpose  : Strips Aurora headers, reassembles 19 beats into one 1024-bit
//             word, checks framing and filters on router ID.
//             Optional inter-beat timeout: define DECAP_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module decap_packet
    import aurora_pkt_pkg::*;
#(
    parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] MY_ROUTER_ID = '0
`ifdef DECAP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    input  logic                         data_recv_valid,
    output logic [DATA_WIDTH-1:0]        data_dfx_recv,
    output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
    output logic                         decap_valid,
    output logic                         decap_err,
    output logic                         frame_drop
);

    logic [1:0]                r_state;
    logic [BEAT_CNT_WIDTH-1:0] r_beat_cnt;
    logic [HEADER_WIDTH-1:0]   r_hdr;
    logic                      r_err;
    logic [DATA_WIDTH-1:0]     r_buf;

    logic [HEADER_WIDTH-1:0]   w_beat_hdr;
    logic [PAYLOAD_WIDTH-1:0]  w_payload;
    logic [BEAT_CNT_WIDTH-1:0] w_slot;
    logic                      w_is_last;
    logic                      w_beat_bad;
    logic                      w_timeout;

    assign w_beat_hdr = data_recv[HEADER_WIDTH-1:0];
    assign w_payload  = data_recv[AURORA_DATA_WIDTH-1:HEADER_WIDTH];
    // Outside COLLECT any valid beat starts a new frame, so it lands in slot 0.
    assign w_slot     = (r_state == C_ST_COLLECT) ? r_beat_cnt : '0;
    assign w_is_last  = (r_state == C_ST_COLLECT) &&
                        (r_beat_cnt == BEAT_CNT_WIDTH'(LAST_BEAT));
    assign w_beat_bad = (w_beat_hdr != r_hdr) ||
                        (w_is_last && (|data_recv[AURORA_DATA_WIDTH-1:PAD_LSB]));

`ifdef DECAP_TIMEOUT_EN
    localparam int GAP_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [GAP_WIDTH-1:0] r_gap;

    assign w_timeout = (r_state == C_ST_COLLECT) && !data_recv_valid &&
                       (r_gap == GAP_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if ((r_state != C_ST_COLLECT) || data_recv_valid || w_timeout) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (data_recv_valid) begin
            for (int k = 0; k < LAST_BEAT; k++) begin
                if (w_slot == BEAT_CNT_WIDTH'(k)) begin
                    r_buf[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= w_payload;
                end
            end
            if (w_slot == BEAT_CNT_WIDTH'(LAST_BEAT)) begin
                r_buf[DATA_WIDTH-1 -: LAST_BEAT_BITS] <= w_payload[LAST_BEAT_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= C_ST_IDLE;
            r_beat_cnt      <= '0;
            r_hdr           <= '0;
            r_err           <= 1'b0;
            data_dfx_recv   <= '0;
            header_pkt_recv <= '0;
            decap_valid     <= 1'b0;
            decap_err       <= 1'b0;
            frame_drop      <= 1'b0;
        end else begin
            decap_valid <= 1'b0;
            decap_err   <= 1'b0;
            frame_drop  <= 1'b0;
            case (r_state)
                C_ST_COLLECT: begin
                    if (data_recv_valid) begin
                        if (w_beat_bad) begin
                            r_err <= 1'b1;
                        end
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_is_last) begin
                            r_state <= C_ST_CHECK;
                        end
                    end else if (w_timeout) begin
                        decap_err  <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= C_ST_IDLE;
                    end
                end
                default: begin
                    // Error outranks the ID filter; only an accept touches the data outputs.
                    if (r_state == C_ST_CHECK) begin
                        if (r_err) begin
                            decap_err <= 1'b1;
                        end else if (router_id(r_hdr) != MY_ROUTER_ID) begin
                            frame_drop <= 1'b1;
                        end else begin
                            decap_valid     <= 1'b1;
                            data_dfx_recv   <= r_buf;
                            header_pkt_recv <= r_hdr;
                        end
                    end
                    if (data_recv_valid) begin
                        r_hdr      <= w_beat_hdr;
                        r_err      <= 1'b0;
                        r_beat_cnt <= BEAT_CNT_WIDTH'(1);
                        r_state    <= C_ST_COLLECT;
                    end else begin
                        r_beat_cnt <= '0;
                        r_state    <= C_ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decap_packet.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decap_packet
//  Purpose  : Self-checking bench for decap_packet with a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decap_packet;
    import aurora_pkt_pkg::*;

    localparam int TIMEOUT = 64;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [AURORA_DATA_WIDTH-1:0] data_recv;
    logic                         data_recv_valid;
    logic [DATA_WIDTH-1:0]        data_dfx_recv;
    logic [HEADER_WIDTH-1:0]      header_pkt_recv;
    logic                         decap_valid;
    logic                         decap_err;
    logic                         frame_drop;

    always #5 clk = ~clk;

    decap_packet #(
        .MY_ROUTER_ID(2'd0)
`ifdef DECAP_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TIMEOUT)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_recv       (data_recv),
        .data_recv_valid (data_recv_valid),
        .data_dfx_recv   (data_dfx_recv),
        .header_pkt_recv (header_pkt_recv),
        .decap_valid     (decap_valid),
        .decap_err       (decap_err),
        .frame_drop      (frame_drop)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_drop   = 0;
    int cyc      = 0;
    int valid_cyc = 0;
    int last_cyc  = 0;
    int gaps[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [DATA_WIDTH-1:0] act,
                            input logic [DATA_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got low64 %h expected low64 %h (%0d bits differ)",
                     name, act[63:0], exp[63:0], $countones(act ^ exp));
        end
    endtask

    // Frame-level reference: a queue of received beats, evaluated one cycle after the 19th.
    logic [63:0]           m_beats[$];
    bit                    m_check = 0;
    int                    m_gap   = 0;
    logic [DATA_WIDTH-1:0] m_data  = '0;
    logic [8:0]            m_hdr   = '0;
    bit                    m_v = 0, m_e = 0, m_d = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beats.delete();
            m_check = 0; m_gap = 0;
            m_data = '0; m_hdr = '0;
            m_v = 0; m_e = 0; m_d = 0;
        end else begin
            m_v = 0; m_e = 0; m_d = 0;
            if (m_check) begin
                logic [8:0] h0;
                bit bad;
                h0  = m_beats[0][8:0];
                bad = (m_beats[18][63:43] != 21'd0);
                for (int k = 0; k < 19; k++) if (m_beats[k][8:0] != h0) bad = 1;
                if (bad) m_e = 1;
                else if (h0[1:0] != 2'd0) m_d = 1;
                else begin
                    m_v = 1;
                    m_hdr = h0;
                    for (int k = 0; k < 18; k++) m_data[k*55 +: 55] = m_beats[k][63:9];
                    m_data[1023:990] = m_beats[18][42:9];
                end
                m_beats.delete();
                m_check = 0;
            end
            if (data_recv_valid) begin
                m_beats.push_back(data_recv);
                m_gap = 0;
                if (m_beats.size() == 19) m_check = 1;
            end else if (m_beats.size() > 0 && !m_check) begin
`ifdef DECAP_TIMEOUT_EN
                m_gap++;
                if (m_gap == TIMEOUT) begin
                    m_e = 1;
                    m_beats.delete();
                    m_gap = 0;
                end
`endif
            end
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("decap_valid", 64'(decap_valid), 64'(m_v));
        chk("decap_err", 64'(decap_err), 64'(m_e));
        chk("frame_drop", 64'(frame_drop), 64'(m_d));
        chk("header_pkt_recv", 64'(header_pkt_recv), 64'(m_hdr));
        chk_word("data_dfx_recv", data_dfx_recv, m_data);
        if (decap_valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
        if (decap_err === 1'b1) n_err++;
        if (frame_drop === 1'b1) n_drop++;
    end

    function automatic logic [DATA_WIDTH-1:0] rand_word();
        logic [DATA_WIDTH-1:0] w;
        for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic idle(input int n);
        data_recv_valid = 1'b0;
        data_recv = {$urandom(), $urandom()};
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [DATA_WIDTH-1:0] word, input logic [8:0] hdr,
                              input int nbeats, input int bad_hdr_beat, input bit bad_pad);
        logic [54:0] pl;
        logic [63:0] b;
        for (int k = 0; k < nbeats; k++) begin
            if (k < 18) pl = word[k*55 +: 55];
            else        pl = {21'd0, word[1023:990]};
            b = {pl, hdr};
            if (k == bad_hdr_beat) b[8:0] = hdr ^ 9'h004;
            if (bad_pad && k == 18) b[50] = 1'b1;
            data_recv = b;
            data_recv_valid = 1'b1;
            last_cyc = cyc;
            @(posedge clk); #1;
            if (gaps[k] > 0) idle(gaps[k]);
        end
        data_recv_valid = 1'b0;
    endtask

    task automatic clear_gaps();
        for (int k = 0; k < 19; k++) gaps[k] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_WIDTH-1:0] wa, wb;
        int bv, be, bd;
        logic [8:0] hdr;
        int bad;
        bit pad;

        data_recv = '0;
        data_recv_valid = 1'b0;
        rst_n = 1'b0;
        clear_gaps();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(decap_valid), 64'd0);
        chk("reset_err", 64'(decap_err), 64'd0);
        chk("reset_drop", 64'(frame_drop), 64'd0);
        chk("reset_hdr", 64'(header_pkt_recv), 64'd0);
        chk_word("reset_data", data_dfx_recv, '0);
        rst_n = 1'b1;
        idle(2);

        // Reset in the middle of a frame, then a clean frame
        wa = rand_word();
        send_frame(wa, 9'h0A0, 8, -1, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        bv = n_valid; be = n_err; bd = n_drop;
        idle(30);
        chk("rst_mid_valid_cnt", 64'(n_valid - bv), 64'd0);
        chk("rst_mid_err_cnt", 64'(n_err - be), 64'd0);
        chk("rst_mid_drop_cnt", 64'(n_drop - bd), 64'd0);

        wa = rand_word();
        bv = n_valid;
        send_frame(wa, 9'h0A0, 19, -1, 0);
        idle(4);
        chk("clean_valid_cnt", 64'(n_valid - bv), 64'd1);
        chk_word("clean_data", data_dfx_recv, wa);
        chk("clean_hdr", 64'(header_pkt_recv), 64'h0A0);
        chk("clean_latency", 64'(valid_cyc - last_cyc), 64'd2);

        // Stalls between beats 4/5 and 17/18
        wa = rand_word();
        gaps[4] = 3; gaps[17] = 3;
        bv = n_valid;
        send_frame(wa, 9'h0A0, 19, -1, 0);
        clear_gaps();
        idle(4);
        chk("stall_valid_cnt", 64'(n_valid - bv), 64'd1);
        chk_word("stall_data", data_dfx_recv, wa);
        chk("stall_latency", 64'(valid_cyc - last_cyc), 64'd2);

        // Back-to-back: second frame's beat 0 lands in the check cycle
        wa = rand_word();
        wb = rand_word();
        bv = n_valid;
        send_frame(wa, 9'h0A0, 19, -1, 0);
        send_frame(wb, 9'h13C, 19, -1, 0);
        idle(4);
        chk("b2b_valid_cnt", 64'(n_valid - bv), 64'd2);
        chk_word("b2b_data", data_dfx_recv, wb);
        chk("b2b_hdr", 64'(header_pkt_recv), 64'h13C);

        // Frame for another router
        bv = n_valid; bd = n_drop;
        send_frame(rand_word(), 9'h0A1, 19, -1, 0);
        idle(4);
        chk("drop_cnt", 64'(n_drop - bd), 64'd1);
        chk("drop_valid_cnt", 64'(n_valid - bv), 64'd0);
        chk_word("drop_data_kept", data_dfx_recv, wb);

        // Header mismatch on beat 9, then pad bit 50 on beat 18
        bv = n_valid; be = n_err; bd = n_drop;
        send_frame(rand_word(), 9'h0A0, 19, 9, 0);
        idle(4);
        send_frame(rand_word(), 9'h0A1, 19, -1, 1);
        idle(4);
        chk("err_cnt", 64'(n_err - be), 64'd2);
        chk("err_valid_cnt", 64'(n_valid - bv), 64'd0);
        chk("err_drop_cnt", 64'(n_drop - bd), 64'd0);
        chk_word("err_data_kept", data_dfx_recv, wb);
        chk("err_hdr_kept", 64'(header_pkt_recv), 64'h13C);

`ifdef DECAP_TIMEOUT_EN
        be = n_err; bv = n_valid;
        send_frame(rand_word(), 9'h0A0, 11, -1, 0);
        idle(TIMEOUT + 4);
        chk("timeout_err_cnt", 64'(n_err - be), 64'd1);
        chk("timeout_valid_cnt", 64'(n_valid - bv), 64'd0);
        wa = rand_word();
        gaps[10] = TIMEOUT - 1;
        be = n_err; bv = n_valid;
        send_frame(wa, 9'h0A0, 19, -1, 0);
        clear_gaps();
        idle(4);
        chk("gap63_err_cnt", 64'(n_err - be), 64'd0);
        chk("gap63_valid_cnt", 64'(n_valid - bv), 64'd1);
        chk_word("gap63_data", data_dfx_recv, wa);
`else
        wa = rand_word();
        gaps[10] = 100;
        be = n_err; bv = n_valid;
        send_frame(wa, 9'h0A0, 19, -1, 0);
        clear_gaps();
        idle(4);
        chk("longgap_err_cnt", 64'(n_err - be), 64'd0);
        chk("longgap_valid_cnt", 64'(n_valid - bv), 64'd1);
        chk_word("longgap_data", data_dfx_recv, wa);
`endif

        // Randomized frames checked cycle by cycle against the model
        for (int f = 0; f < 14; f++) begin
            hdr = 9'($urandom());
            hdr[1:0] = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            for (int k = 0; k < 19; k++)
                gaps[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
            bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 18)) : -1;
            pad = ($urandom_range(0, 7) == 0);
            send_frame(rand_word(), hdr, 19, bad, pad);
            clear_gaps();
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
